serial_add_sub: RTL and testbench

//  Parametrised multi-cycle adder/subtractor, successor to the single-bit half adder.

---
 rtl/serial_add_sub_pkg.sv | 27 ++
 rtl/serial_add_sub_full_adder_chain.sv | 26 ++
 rtl/serial_add_sub.sv | 99 +++++++++
 tb/tb_serial_add_sub.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
// State encodings are plain 2-bit constants so older tools can consume them.
package serial_add_sub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Smallest r with 2**r >= n; used to size the digit counter.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_add_sub_full_adder_chain.sv
// Combinational ripple of DIGIT full-adder cells; also exposes the carry
// entering the top cell so the caller can derive signed overflow.
module full_adder_chain #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[DIGIT];
    assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per
// cycle, LSB digit first, with a start/busy/done handshake.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             c_reg;
    logic [WIDTH-1:0] sum_sh;

    logic [DIGIT-1:0] dsum;
    logic             dcout;
    logic             dcmsb;
    logic [WIDTH-1:0] dext;
    logic [WIDTH-1:0] next_sh;

    full_adder_chain #(.DIGIT(DIGIT)) u_chain (
        .a    (a_reg[DIGIT-1:0]),
        .b    (b_reg[DIGIT-1:0]),
        .cin  (c_reg),
        .sum  (dsum),
        .cout (dcout),
        .cmsb (dcmsb)
    );

    // New digit enters from the MSB side; after N shifts the LSB digit sits at bit 0.
    assign dext    = WIDTH'(dsum) << (WIDTH - DIGIT);
    assign next_sh = (sum_sh >> DIGIT) | dext;

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            c_reg    <= 1'b0;
            sum_sh   <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_reg <= val1;
                        b_reg <= (mode == MODE_SUB) ? ~val2 : val2;
                        c_reg <= mode;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_reg  <= a_reg >> DIGIT;
                    b_reg  <= b_reg >> DIGIT;
                    c_reg  <= dcout;
                    sum_sh <= next_sh;
                    // On the last digit the chain's top cell is bit WIDTH-1 of the word.
                    if (cnt == LAST) begin
                        sum      <= next_sh;
                        carry    <= dcout;
                        overflow <= dcmsb ^ dcout;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed checks of the 8-bit/1-digit adder plus a 16-bit/4-digit instance
// compared against an arithmetic model.
module tb_serial_add_sub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [7:0]  val1 = '0;
    logic [7:0]  val2 = '0;
    logic        busy, done, carry, overflow;
    logic [7:0]  sum;

    logic        start16 = 1'b0;
    logic        mode16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        busy16, done16, carry16, ovf16;
    logic [15:0] sum16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .val1(val1), .val2(val2),
        .busy(busy), .done(done), .sum(sum), .carry(carry), .overflow(overflow)
    );

    serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .mode(mode16), .val1(a16), .val2(b16),
        .busy(busy16), .done(done16), .sum(sum16), .carry(carry16), .overflow(ovf16)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; operands are scrambled once the start edge has passed.
    task automatic applyStimulus(input logic m, input logic [7:0] x, input logic [7:0] y);
        start = 1'b1;
        mode  = m;
        val1  = x;
        val2  = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        val1  = 8'($urandom);
        val2  = 8'($urandom);
        mode  = 1'($urandom);
    endtask

    task automatic waitDone(input int lat0, input int busy0, output int lat, output int busyCnt);
        bit seen;
        seen    = 1'b0;
        lat     = lat0;
        busyCnt = busy0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (busy) busyCnt++;
            if (done) seen = 1'b1;
        end
        if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
        else checkOutput("busy_at_done", 32'(busy), 32'd0);
    endtask

    task automatic checkResult(input string tag, input logic [7:0] s, input logic c,
                               input logic o, input int lat);
        checkOutput({tag, "_sum"}, 32'(sum), 32'(s));
        checkOutput({tag, "_carry"}, 32'(carry), 32'(c));
        checkOutput({tag, "_ovf"}, 32'(overflow), 32'(o));
        checkOutput({tag, "_latency"}, 32'(lat), 32'd9);
    endtask

    task automatic op16(input logic m, input logic [15:0] x, input logic [15:0] y, output int lat);
        bit seen;
        start16 = 1'b1;
        mode16  = m;
        a16     = x;
        b16     = y;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        a16     = 16'($urandom);
        b16     = 16'($urandom);
        seen    = 1'b0;
        lat     = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (done16) seen = 1'b1;
        end
        if (!seen) checkOutput("done16_timeout", 32'd0, 32'd1);
    endtask

    // Independent arithmetic reference: {overflow, carry, sum}.
    function automatic logic [17:0] model16(input logic m, input logic [15:0] x, input logic [15:0] y);
        logic [16:0] full;
        logic [15:0] s;
        logic        ov;
        if (m) full = {1'b0, x} + {1'b0, ~y} + 17'd1;
        else   full = {1'b0, x} + {1'b0, y};
        s  = full[15:0];
        ov = m ? ((x[15] != y[15]) && (s[15] != x[15]))
               : ((x[15] == y[15]) && (s[15] != x[15]));
        return {ov, full[16], s};
    endfunction

    initial begin
        int lat, bc, dones;
        logic [17:0] exp16;
        logic [15:0] ra, rb;
        logic        rm;

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_sum", 32'(sum), 32'd0);
        checkOutput("rst_carry", 32'(carry), 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);
        checkOutput("rst_busy16", 32'(busy16), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(1'b0, 8'h0F, 8'h01);
        waitDone(0, 0, lat, bc);
        checkResult("add_0f_01", 8'h10, 1'b0, 1'b0, lat);
        checkOutput("add_0f_01_busycycles", 32'(bc), 32'd8);

        applyStimulus(1'b0, 8'hFF, 8'h01);
        waitDone(0, 0, lat, bc);
        checkResult("add_ff_01", 8'h00, 1'b1, 1'b0, lat);

        applyStimulus(1'b0, 8'h7F, 8'h01);
        waitDone(0, 0, lat, bc);
        checkResult("add_7f_01", 8'h80, 1'b0, 1'b1, lat);

        applyStimulus(1'b1, 8'h05, 8'h07);
        waitDone(0, 0, lat, bc);
        checkResult("sub_05_07", 8'hFE, 1'b0, 1'b0, lat);

        applyStimulus(1'b1, 8'h80, 8'h01);
        waitDone(0, 0, lat, bc);
        checkResult("sub_80_01", 8'h7F, 1'b1, 1'b1, lat);

        // A start pulse in the middle of RUN must not disturb the running subtract.
        applyStimulus(1'b1, 8'h10, 8'h01);
        repeat (2) @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        val1  = 8'hAA;
        val2  = 8'h55;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(2, 2, lat, bc);
        checkResult("sub_ignore_start", 8'h0F, 1'b1, 1'b0, lat);
        checkOutput("sub_ignore_busycycles", 32'(bc), 32'd8);

        applyStimulus(1'b0, 8'hAA, 8'h55);
        waitDone(0, 0, lat, bc);
        checkResult("b2b_aa_55", 8'hFF, 1'b0, 1'b0, lat);

        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("no_extra_done", 32'(dones), 32'd0);
        checkOutput("idle_held_sum", 32'(sum), 32'hFF);

        applyStimulus(1'b0, 8'h33, 8'h11);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_sum", 32'(sum), 32'd0);
        checkOutput("midrst_carry", 32'(carry), 32'd0);
        checkOutput("midrst_ovf", 32'(overflow), 32'd0);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("midrst_no_done", 32'(dones), 32'd0);

        applyStimulus(1'b0, 8'h33, 8'h11);
        waitDone(0, 0, lat, bc);
        checkResult("after_rst", 8'h44, 1'b0, 1'b0, lat);

        op16(1'b0, 16'h8000, 16'h8000, lat);
        checkOutput("w16_sum", 32'(sum16), 32'h0000);
        checkOutput("w16_carry", 32'(carry16), 32'd1);
        checkOutput("w16_ovf", 32'(ovf16), 32'd1);
        checkOutput("w16_latency", 32'(lat), 32'd5);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rm = 1'($urandom);
            exp16 = model16(rm, ra, rb);
            op16(rm, ra, rb, lat);
            checkOutput("rnd16_sum", 32'(sum16), 32'(exp16[15:0]));
            checkOutput("rnd16_carry", 32'(carry16), 32'(exp16[16]));
            checkOutput("rnd16_ovf", 32'(ovf16), 32'(exp16[17]));
            checkOutput("rnd16_latency", 32'(lat), 32'd5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
